// File: rtl/norm_pkg.sv
// Shared types and constants for the normalizer: FSM states, widths, step schedule.
// Pure declarations, no timing or handshake behaviour of its own.
package norm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned NSTEPS = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Binary-search schedule: 16, 8, 4, 2, 1 for steps 0..4.
  function automatic logic [AMT_W-1:0] step_width(input logic [2:0] step);
    return AMT_W'(16 >> step);
  endfunction

endpackage

// File: rtl/norm_step.sv
// One normalization step: tests W edge bits and shifts by W when they are all zero.
// Purely combinational with no latency; it has no handshake and never applies backpressure.
module norm_step
  import norm_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic              dir_i,
  input  logic [AMT_W-1:0]  w_i,
  output logic [DATA_W-1:0] data_o,
  output logic              hit_o
);

  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] test_mask;

  always_comb begin
    ones      = '1;
    // dir 0 tests the top W bits, dir 1 tests the bottom W bits.
    test_mask = dir_i ? ~(ones << w_i) : ~(ones >> w_i);
    hit_o     = ((data_i & test_mask) == '0);
    data_o    = data_i;
    if (hit_o) begin
      data_o = dir_i ? (data_i >> w_i) : (data_i << w_i);
    end
  end

endmodule

// File: rtl/normalizer.sv
// Leading/trailing-zero normalizer: 5 RUN cycles, so out_valid rises 6 cycles after the input handshake.
// One operation at a time; outputs are held until out_ready is seen, and in_ready stays low meanwhile.
module normalizer
  import norm_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic              dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] norm,
  output logic [AMT_W-1:0]  amt,
  output logic              zero
);

  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [DATA_W-1:0] norm_q, norm_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic              zero_q, zero_d;
  logic              dir_q, dir_d;

  logic [AMT_W-1:0]  step_w;
  logic [DATA_W-1:0] step_data;
  logic              step_hit;

  assign step_w = step_width(step_q);

  norm_step u_step (
    .data_i (norm_q),
    .dir_i  (dir_q),
    .w_i    (step_w),
    .data_o (step_data),
    .hit_o  (step_hit)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    norm_d  = norm_q;
    amt_d   = amt_q;
    zero_d  = zero_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          norm_d  = a;
          dir_d   = dir;
          zero_d  = (a == '0);
          amt_d   = '0;
          step_d  = '0;
        end
      end
      RUN: begin
        norm_d = step_data;
        // Widths sum to 31, so amt cannot wrap even when every step fires.
        if (step_hit) begin
          amt_d = amt_q + step_w;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'(NSTEPS - 1)) begin
          state_d = DONE;
          step_d  = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      step_q  <= '0;
      norm_q  <= '0;
      amt_q   <= '0;
      zero_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      norm_q  <= norm_d;
      amt_q   <= amt_d;
      zero_q  <= zero_d;
      dir_q   <= dir_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign norm      = norm_q;
  assign amt       = amt_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_normalizer.sv
// Directed bench for normalizer: expected results are queued at issue and popped by a monitor.
// Also checks reset values, latency, stall holding, ignored inputs and reset abort.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic        dir = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] norm;
  logic [4:0]  amt;
  logic        zero;

  normalizer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .norm      (norm),
    .amt       (amt),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] n;
    logic [4:0]  amt;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-low-phase, after the driver's negedge updates have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got result 0x%08h amt %0d with empty queue", norm, amt);
        end else begin
          e = sb.pop_front();
          chk("sb_norm", norm, e.n);
          chk("sb_amt", 32'(amt), 32'(e.amt));
          chk("sb_zero", 32'(zero), 32'(e.z));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready still 0 after %0d cycles, required 1", n);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first DONE cycle.
  task automatic issue(input logic [31:0] av, input logic dv, input logic [31:0] en,
                       input logic [4:0] ea, input logic ez, input logic stall);
    int cyc;
    wait_ready();
    in_valid  = 1'b1;
    a         = av;
    dir       = dv;
    out_ready = !stall;
    sb.push_back(exp_t'{n: en, amt: ea, z: ez});
    @(posedge clk);
    @(negedge clk);
    // Garbage offered during RUN must be ignored.
    a   = ~av;
    dir = ~dv;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency_cycle", 32'(cyc), 32'd6);
  endtask

  task automatic after_pop(input logic [31:0] en);
    @(negedge clk);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_norm_hold", norm, en);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_norm", norm, 32'd0);
    chk("rst_amt", 32'(amt), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    issue(32'h0001_0000, 1'b0, 32'h8000_0000, 5'd15, 1'b0, 1'b0);
    after_pop(32'h8000_0000);
    issue(32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0, 1'b0, 1'b0);
    after_pop(32'h8000_0000);
    issue(32'h0000_0100, 1'b1, 32'h0000_0001, 5'd8, 1'b0, 1'b0);
    after_pop(32'h0000_0001);
    issue(32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1, 1'b0);
    after_pop(32'h0000_0000);
    issue(32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1, 1'b0);
    after_pop(32'h0000_0000);

    // Stall in DONE for 3 cycles with a competing operand offered.
    issue(32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8, 1'b0, 1'b1);
    in_valid = 1'b1;
    a        = 32'hFFFF_FFFF;
    dir      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_norm", norm, 32'hF000_0000);
      chk("stall_amt", 32'(amt), 32'd8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    after_pop(32'hF000_0000);

    // Back-to-back operands, popped in issue order.
    issue(32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
    issue(32'h8000_0000, 1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b0);
    issue(32'h0000_A000, 1'b1, 32'h0000_0005, 5'd13, 1'b0, 1'b0);
    after_pop(32'h0000_0005);

    // Reset in the third RUN cycle aborts the operation.
    wait_ready();
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    dir      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_norm", norm, 32'd0);
    chk("abort_amt", 32'(amt), 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(32'h0000_F000, 1'b1, 32'h0000_000F, 5'd12, 1'b0, 1'b0);
    after_pop(32'h0000_000F);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
